// File: rtl/gpio_cond.sv
// gpio_cond: board I/O conditioner sitting between raw FPGA pins and the SoC
// GPIO ports. Synchronises and debounces an input bank, reports levels, edge
// pulses and sticky event flags with an interrupt, stretches a button-driven
// system reset, and drives a registered LED bank with optional blink.
module gpio_cond #(
    parameter int unsigned      NIN        = 8,
    parameter int unsigned      NOUT       = 8,
    parameter logic [NIN-1:0]   IN_INV     = '0,
    parameter int unsigned      SYNC       = 2,
    parameter int unsigned      DEB_CNT    = 50000,
    parameter logic [NIN-1:0]   RISE_MASK  = '1,
    parameter logic [NIN-1:0]   FALL_MASK  = '0,
    parameter int unsigned      RST_BIT    = 0,
    parameter int unsigned      RST_HOLD   = 1024,
    parameter int unsigned      BLINK_BITS = 23
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NIN-1:0]  pin_in,
    output logic [NIN-1:0]  in_level,
    output logic [NIN-1:0]  in_rise,
    output logic [NIN-1:0]  in_fall,
    output logic [NIN-1:0]  ev_flag,
    input  logic [NIN-1:0]  ev_clr,
    output logic            irq,
    output logic            sys_rst,
    input  logic [NOUT-1:0] out_data,
    input  logic [NOUT-1:0] out_blink,
    output logic [NOUT-1:0] pin_out
);

    // Debounce counter only needs to reach DEB_CNT-1; hold counter reaches RST_HOLD.
    localparam int CW = $clog2(DEB_CNT + 1);
    localparam int HW = $clog2(RST_HOLD + 1);

    logic [NIN-1:0]        sync_q [SYNC];
    logic [NIN-1:0]        samp;
    logic [NIN-1:0]        lvl_next;
    logic [NIN-1:0]        rise_next;
    logic [NIN-1:0]        fall_next;
    logic [NIN-1:0]        flag_set;
    logic [HW-1:0]         hold_q;
    logic [HW-1:0]         hold_next;
    logic [BLINK_BITS-1:0] blink_q;
    logic                  blink_phase;

    // Inversion is applied before the first flop so the chain carries the logical level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= pin_in ^ IN_INV;
            for (int k = 1; k < SYNC; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign samp = sync_q[SYNC-1];

    // One stability counter per channel; a sample equal to the current level
    // restarts it, so acceptance needs DEB_CNT consecutive differing samples.
    for (genvar i = 0; i < NIN; i++) begin : g_deb
        logic [CW-1:0] cnt_q;
        logic          accept;

        assign accept       = (samp[i] != in_level[i]) && (cnt_q == CW'(DEB_CNT - 1));
        assign lvl_next[i]  = accept ? samp[i] : in_level[i];
        assign rise_next[i] = accept & samp[i];
        assign fall_next[i] = accept & ~samp[i];

        // Count consecutive samples that disagree with the accepted level.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (samp[i] == in_level[i]) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Flags are set from the same term that produces the edge pulses, so they
    // appear on the same edge; a set takes priority over a clear.
    assign flag_set = (rise_next & RISE_MASK) | (fall_next & FALL_MASK);

    // Level, edge pulses, sticky flags and the interrupt derived from them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_level <= '0;
            in_rise  <= '0;
            in_fall  <= '0;
            ev_flag  <= '0;
            irq      <= 1'b0;
        end else begin
            in_level <= lvl_next;
            in_rise  <= rise_next;
            in_fall  <= fall_next;
            ev_flag  <= (ev_flag & ~ev_clr) | flag_set;
            irq      <= |ev_flag;
        end
    end

    // Hold counter reloads while the reset button is held and counts down after release.
    always_comb begin
        hold_next = hold_q;
        if (in_level[RST_BIT]) begin
            hold_next = HW'(RST_HOLD);
        end else if (hold_q != '0) begin
            hold_next = hold_q - HW'(1);
        end
    end

    // sys_rst rises with the debounced press and falls as the hold counter reaches zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= HW'(RST_HOLD);
            sys_rst <= 1'b1;
        end else begin
            hold_q  <= hold_next;
            sys_rst <= lvl_next[RST_BIT] | (hold_next != '0);
        end
    end

    // Free-running blink divider; its MSB is the blink phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_q + BLINK_BITS'(1);
        end
    end

    assign blink_phase = blink_q[BLINK_BITS-1];

    // Registered LED drive; blinking channels are gated by the blink phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_out <= '0;
        end else begin
            pin_out <= out_data & (~out_blink | {NOUT{blink_phase}});
        end
    end

endmodule

// File: tb/tb_gpio_cond.sv
// tb_gpio_cond: directed, table-driven bench for gpio_cond with a short
// debounce, short reset hold and a 3-bit blink divider.
module tb_gpio_cond;

    typedef struct {
        logic [7:0] pin;
        logic [7:0] clr;
        logic [7:0] od;
        logic [7:0] lvl;
        logic [7:0] rise;
        logic [7:0] fall;
        logic [7:0] flag;
        logic       irq;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] pin_in;
    logic [7:0] in_level;
    logic [7:0] in_rise;
    logic [7:0] in_fall;
    logic [7:0] ev_flag;
    logic [7:0] ev_clr;
    logic       irq;
    logic       sys_rst;
    logic [7:0] out_data;
    logic [7:0] out_blink;
    logic [7:0] pin_out;

    int   total;
    int   bad;
    int   cyc;
    int   nvec;
    vec_t vecs [64];

    gpio_cond #(
        .NIN        (8),
        .NOUT       (8),
        .IN_INV     (8'h01),
        .SYNC       (2),
        .DEB_CNT    (4),
        .RISE_MASK  (8'hFF),
        .FALL_MASK  (8'h00),
        .RST_BIT    (0),
        .RST_HOLD   (8),
        .BLINK_BITS (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pin_in    (pin_in),
        .in_level  (in_level),
        .in_rise   (in_rise),
        .in_fall   (in_fall),
        .ev_flag   (ev_flag),
        .ev_clr    (ev_clr),
        .irq       (irq),
        .sys_rst   (sys_rst),
        .out_data  (out_data),
        .out_blink (out_blink),
        .pin_out   (pin_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release, used as the blink reference.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic addRows(input int n, input logic [7:0] pin, input logic [7:0] clr,
                           input logic [7:0] od, input logic [7:0] lvl, input logic [7:0] rise,
                           input logic [7:0] fall, input logic [7:0] flag, input logic irq_e);
        for (int k = 0; k < n; k++) begin
            vecs[nvec].pin  = pin;
            vecs[nvec].clr  = clr;
            vecs[nvec].od   = od;
            vecs[nvec].lvl  = lvl;
            vecs[nvec].rise = rise;
            vecs[nvec].fall = fall;
            vecs[nvec].flag = flag;
            vecs[nvec].irq  = irq_e;
            nvec = nvec + 1;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        pin_in    = v.pin;
        ev_clr    = v.clr;
        out_data  = v.od;
        out_blink = 8'h00;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        nvec  = 0;
        rst_n     = 1'b0;
        pin_in    = 8'h01;
        ev_clr    = 8'h00;
        out_data  = 8'h00;
        out_blink = 8'h00;

        // Per-edge vectors: ch0 idles high (inverted button), ch3 rise, clear,
        // fall, bounce, then set-vs-clear on a multi-channel rise.
        addRows(1, 8'h09, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        addRows(1, 8'h09, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        addRows(3, 8'h09, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        addRows(1, 8'h09, 8'h00, 8'hC3, 8'h08, 8'h08, 8'h00, 8'h08, 1'b0);
        addRows(1, 8'h09, 8'h00, 8'hFF, 8'h08, 8'h00, 8'h00, 8'h08, 1'b1);
        addRows(1, 8'h09, 8'h08, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 1'b1);
        addRows(1, 8'h09, 8'h00, 8'h12, 8'h08, 8'h00, 8'h00, 8'h00, 1'b0);
        addRows(5, 8'h01, 8'h00, 8'h34, 8'h08, 8'h00, 8'h00, 8'h00, 1'b0);
        addRows(1, 8'h01, 8'h00, 8'h56, 8'h00, 8'h00, 8'h08, 8'h00, 1'b0);
        addRows(1, 8'h01, 8'h00, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        addRows(3, 8'h09, 8'h00, 8'h9A, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        addRows(1, 8'h01, 8'h00, 8'hBC, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        addRows(5, 8'h09, 8'h00, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        addRows(1, 8'h09, 8'h00, 8'hF0, 8'h08, 8'h08, 8'h00, 8'h08, 1'b0);
        addRows(1, 8'h09, 8'h00, 8'h0F, 8'h08, 8'h00, 8'h00, 8'h08, 1'b1);
        addRows(5, 8'h01, 8'h00, 8'h11, 8'h08, 8'h00, 8'h00, 8'h08, 1'b1);
        addRows(1, 8'h01, 8'h00, 8'h22, 8'h00, 8'h00, 8'h08, 8'h08, 1'b1);
        addRows(5, 8'h69, 8'h00, 8'h44, 8'h00, 8'h00, 8'h00, 8'h08, 1'b1);
        addRows(1, 8'h69, 8'h08, 8'h88, 8'h68, 8'h68, 8'h00, 8'h68, 1'b1);
        addRows(1, 8'h69, 8'h00, 8'h99, 8'h68, 8'h00, 8'h00, 8'h68, 1'b1);
        addRows(1, 8'h69, 8'h08, 8'hAA, 8'h68, 8'h00, 8'h00, 8'h60, 1'b1);
        addRows(1, 8'h69, 8'h60, 8'hBB, 8'h68, 8'h00, 8'h00, 8'h00, 1'b1);
        addRows(1, 8'h69, 8'h00, 8'hCC, 8'h68, 8'h00, 8'h00, 8'h00, 1'b0);

        // Values held while reset is asserted.
        repeat (3) tick();
        checkOutput("rst_level",  in_level, 8'h00);
        checkOutput("rst_rise",   in_rise,  8'h00);
        checkOutput("rst_fall",   in_fall,  8'h00);
        checkOutput("rst_flag",   ev_flag,  8'h00);
        checkOutput("rst_irq",    irq,      1'b0);
        checkOutput("rst_sysrst", sys_rst,  1'b1);
        checkOutput("rst_pinout", pin_out,  8'h00);

        // sys_rst falls exactly RST_HOLD edges after release.
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checkOutput($sformatf("rel_sysrst_e%0d", e), sys_rst, (e < 8) ? 1'b1 : 1'b0);
            checkOutput($sformatf("rel_level_e%0d", e), in_level, 8'h00);
            checkOutput($sformatf("rel_irq_e%0d", e), irq, 1'b0);
        end

        for (int i = 0; i < nvec; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_level", i + 1), in_level, vecs[i].lvl);
            checkOutput($sformatf("v%0d_rise", i + 1),  in_rise,  vecs[i].rise);
            checkOutput($sformatf("v%0d_fall", i + 1),  in_fall,  vecs[i].fall);
            checkOutput($sformatf("v%0d_flag", i + 1),  ev_flag,  vecs[i].flag);
            checkOutput($sformatf("v%0d_irq", i + 1),   irq,      vecs[i].irq);
            checkOutput($sformatf("v%0d_sysrst", i + 1), sys_rst, 1'b0);
            checkOutput($sformatf("v%0d_pinout", i + 1), pin_out, vecs[i].od);
        end

        // Reset button (inverted ch0, pressed = pin low) held 20 edges, then released.
        for (int e = 1; e <= 40; e++) begin
            pin_in = (e <= 20) ? 8'h68 : 8'h69;
            tick();
            checkOutput($sformatf("btn_sysrst_e%0d", e), sys_rst, (e >= 6 && e < 34) ? 1'b1 : 1'b0);
            checkOutput($sformatf("btn_level0_e%0d", e), in_level[0], (e >= 6 && e < 26) ? 1'b1 : 1'b0);
        end

        // Re-press during the countdown reloads the hold.
        for (int e = 1; e <= 45; e++) begin
            pin_in = ((e <= 10) || (e >= 18 && e <= 29)) ? 8'h68 : 8'h69;
            tick();
            checkOutput($sformatf("rep_sysrst_e%0d", e), sys_rst, (e >= 6 && e < 43) ? 1'b1 : 1'b0);
            checkOutput($sformatf("rep_level0_e%0d", e), in_level[0],
                        ((e >= 6 && e < 16) || (e >= 23 && e < 35)) ? 1'b1 : 1'b0);
        end

        // Blink: low nibble follows bit 2 of the divider value before each edge.
        pin_in    = 8'h69;
        out_data  = 8'hFF;
        out_blink = 8'h0F;
        for (int k = 0; k < 16; k++) begin
            int  prev;
            logic ph;
            tick();
            prev = cyc - 1;
            ph   = prev[2];
            checkOutput($sformatf("blink_k%0d", k), pin_out, {4'hF, {4{ph}}});
        end

        // Asynchronous reset clears state without waiting for a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_level",  in_level, 8'h00);
        checkOutput("arst_flag",   ev_flag,  8'h00);
        checkOutput("arst_irq",    irq,      1'b0);
        checkOutput("arst_sysrst", sys_rst,  1'b1);
        checkOutput("arst_pinout", pin_out,  8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
